// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back unit: load extraction/extension, register-file write port.
// Optional retired-instruction counter enabled by defining WB_RETCNT_EN.
module wb_stage #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          Stall,
    input  logic          Flush,
    input  logic          mem_valid,
    input  logic          mem_RegWr,
    input  logic          mem_MemtoReg,
    input  logic [2:0]    mem_LdType,
    input  logic [AW-1:0] mem_Rw,
    input  logic [DW-1:0] mem_ALUout,
    input  logic [DW-1:0] mem_dout,
    output logic          WrEn,
    output logic [AW-1:0] Rw,
    output logic [DW-1:0] busW,
    output logic          wb_valid,
    output logic [31:0]   RetCnt
);

    logic          valid_q, valid_d;
    logic          regwr_q, regwr_d;
    logic [AW-1:0] rw_q, rw_d;
    logic [DW-1:0] busw_q, busw_d;

    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] result;
    logic          load_en;

    // Little-endian lane select; a[0] is ignored for halfwords (no misalignment trap).
    always_comb begin
        ld_byte = '0;
        case (mem_ALUout[1:0])
            2'd0:    ld_byte = mem_dout[7:0];
            2'd1:    ld_byte = mem_dout[15:8];
            2'd2:    ld_byte = mem_dout[23:16];
            default: ld_byte = mem_dout[31:24];
        endcase
        ld_half = mem_ALUout[1] ? mem_dout[31:16] : mem_dout[15:0];
    end

    always_comb begin
        ld_data = mem_dout;
        case (mem_LdType)
            3'b001:  ld_data = {{(DW-8){ld_byte[7]}}, ld_byte};
            3'b010:  ld_data = {{(DW-8){1'b0}}, ld_byte};
            3'b011:  ld_data = {{(DW-16){ld_half[15]}}, ld_half};
            3'b100:  ld_data = {{(DW-16){1'b0}}, ld_half};
            default: ld_data = mem_dout;
        endcase
        result = mem_MemtoReg ? ld_data : mem_ALUout;
    end

    assign load_en = !Flush && !Stall;

    always_comb begin
        valid_d = valid_q;
        regwr_d = regwr_q;
        rw_d    = rw_q;
        busw_d  = busw_q;
        if (Flush) begin
            valid_d = 1'b0;
        end else if (!Stall) begin
            valid_d = mem_valid;
            regwr_d = mem_RegWr;
            rw_d    = mem_Rw;
            busw_d  = result;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            valid_q <= 1'b0;
            regwr_q <= 1'b0;
            rw_q    <= '0;
            busw_q  <= '0;
        end else begin
            valid_q <= valid_d;
            regwr_q <= regwr_d;
            rw_q    <= rw_d;
            busw_q  <= busw_d;
        end
    end

`ifdef WB_RETCNT_EN
    logic [31:0] retcnt_q, retcnt_d;

    always_comb begin
        retcnt_d = retcnt_q;
        if (load_en && mem_valid) retcnt_d = retcnt_q + 32'd1;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) retcnt_q <= '0;
        else     retcnt_q <= retcnt_d;
    end

    assign RetCnt = retcnt_q;
`else
    assign RetCnt = '0;
`endif

    assign wb_valid = valid_q;
    assign Rw       = rw_q;
    assign busW     = busw_q;
    assign WrEn     = valid_q && regwr_q && (rw_q != '0);

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, stall/flush/reset sequences, random stimulus vs. model.
module tb_wb_stage;

    logic        Clk = 1'b0;
    logic        Rst, Stall, Flush, mem_valid, mem_RegWr, mem_MemtoReg;
    logic [2:0]  mem_LdType;
    logic [4:0]  mem_Rw;
    logic [31:0] mem_ALUout, mem_dout;
    logic        WrEn, wb_valid;
    logic [4:0]  Rw;
    logic [31:0] busW, RetCnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic        m_valid, m_regwr;
    logic [4:0]  m_rw;
    logic [31:0] m_busw;
    logic [31:0] m_cnt;

    // Behavioural register file sampling the write port on the falling edge
    logic [31:0] rf [32];

    wb_stage #(.DW(32), .AW(5)) dut (
        .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
        .mem_valid(mem_valid), .mem_RegWr(mem_RegWr), .mem_MemtoReg(mem_MemtoReg),
        .mem_LdType(mem_LdType), .mem_Rw(mem_Rw), .mem_ALUout(mem_ALUout),
        .mem_dout(mem_dout), .WrEn(WrEn), .Rw(Rw), .busW(busW),
        .wb_valid(wb_valid), .RetCnt(RetCnt)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (WrEn) rf[Rw] <= busW;

    typedef struct {
        logic        m2r;
        logic [2:0]  ld;
        logic [31:0] alu;
        logic [31:0] dout;
        logic [4:0]  rw;
        logic        regwr;
        logic [31:0] exp_bus;
        logic        exp_wren;
    } vec_t;

    vec_t vt [8];

    function automatic logic [31:0] ref_result(logic m2r, logic [2:0] ld,
                                               logic [31:0] alu, logic [31:0] dout);
        int unsigned a, b, h;
        a = alu % 4;
        b = (dout >> (8 * a)) % 256;
        h = (dout >> (16 * (a / 2))) % 65536;
        if (!m2r) return alu;
        case (ld)
            3'd1:    return (b >= 128) ? 32'(b) + 32'hFFFF_FF00 : 32'(b);
            3'd2:    return 32'(b);
            3'd3:    return (h >= 32768) ? 32'(h) + 32'hFFFF_0000 : 32'(h);
            3'd4:    return 32'(h);
            default: return dout;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_retcnt();
`ifdef WB_RETCNT_EN
        return m_cnt;
`else
        return 32'd0;
`endif
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'(m_valid));
        chk({tag, ".Rw"},       32'(Rw), 32'(m_rw));
        chk({tag, ".busW"},     busW, m_busw);
        chk({tag, ".WrEn"},     32'(WrEn), 32'(m_valid && m_regwr && (m_rw != 5'd0)));
        chk({tag, ".RetCnt"},   RetCnt, exp_retcnt());
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_regwr = 1'b0; m_rw = '0; m_busw = '0; m_cnt = '0;
    endtask

    // Advance one clock: model consumes the current inputs, then outputs are checked after the edge.
    task automatic cycle(input string tag);
        if (Flush) begin
            m_valid = 1'b0;
        end else if (!Stall) begin
            m_valid = mem_valid;
            m_regwr = mem_RegWr;
            m_rw    = mem_Rw;
            m_busw  = ref_result(mem_MemtoReg, mem_LdType, mem_ALUout, mem_dout);
            if (mem_valid) m_cnt = m_cnt + 32'd1;
        end
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic v, input logic rwr, input logic m2r, input logic [2:0] ld,
                         input logic [4:0] rw, input logic [31:0] alu, input logic [31:0] dout);
        mem_valid = v; mem_RegWr = rwr; mem_MemtoReg = m2r; mem_LdType = ld;
        mem_Rw = rw; mem_ALUout = alu; mem_dout = dout;
    endtask

    task automatic async_reset_pulse(input string tag);
        #2 Rst = 1'b1;
        model_reset();
        #1;
        chk({tag, ".WrEn"},     32'(WrEn), 32'd0);
        chk({tag, ".busW"},     busW, 32'd0);
        chk({tag, ".Rw"},       32'(Rw), 32'd0);
        chk({tag, ".wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, ".RetCnt"},   RetCnt, 32'd0);
        #1 Rst = 1'b0;
    endtask

    initial begin
        logic [31:0] cnt_before;

        for (int i = 0; i < 32; i++) rf[i] = '0;
        vt[0] = '{1'b1, 3'd0, 32'h0000_0100, 32'h1234_5678, 5'd8, 1'b1, 32'h1234_5678, 1'b1};
        vt[1] = '{1'b1, 3'd1, 32'h0000_0002, 32'h80FF_7F01, 5'd1, 1'b1, 32'hFFFF_FFFF, 1'b1};
        vt[2] = '{1'b1, 3'd2, 32'h0000_0003, 32'h80FF_7F01, 5'd2, 1'b1, 32'h0000_0080, 1'b1};
        vt[3] = '{1'b1, 3'd3, 32'h0000_0002, 32'h80FF_7F01, 5'd4, 1'b1, 32'hFFFF_80FF, 1'b1};
        vt[4] = '{1'b1, 3'd4, 32'h0000_0001, 32'h80FF_7F01, 5'd5, 1'b1, 32'h0000_7F01, 1'b1};
        vt[5] = '{1'b1, 3'd7, 32'h0000_0000, 32'h80FF_7F01, 5'd6, 1'b1, 32'h80FF_7F01, 1'b1};
        vt[6] = '{1'b0, 3'd0, 32'h0000_0005, 32'hDEAD_BEEF, 5'd0, 1'b1, 32'h0000_0005, 1'b0};
        vt[7] = '{1'b0, 3'd0, 32'h0000_000A, 32'hDEAD_BEEF, 5'd9, 1'b1, 32'h0000_000A, 1'b1};

        Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
        model_reset();
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        check_all("reset");

        // Async reset between edges, then the directed vector table
        drive(1'b1, 1'b1, 1'b1, 3'd0, 5'd7, 32'd0, 32'hFFFF_FFFF);
        cycle("pre");
        async_reset_pulse("async_rst");
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vt[i].regwr, vt[i].m2r, vt[i].ld, vt[i].rw, vt[i].alu, vt[i].dout);
            cycle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.exp_bus", i), busW, vt[i].exp_bus);
            chk($sformatf("vec%0d.exp_wren", i), 32'(WrEn), 32'(vt[i].exp_wren));
        end

        // $0 is never written: rf read of $0 must still be zero
        chk("rf_r0", rf[0], 32'd0);

        // Stall for 3 cycles holding the $9 add while MEM inputs change
        cnt_before = RetCnt;
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'($urandom), 3'($urandom), 5'd12 + 5'(i), $urandom, $urandom);
            cycle($sformatf("stall%0d", i));
            chk($sformatf("stall%0d.Rw", i), 32'(Rw), 32'd9);
            chk($sformatf("stall%0d.busW", i), busW, 32'h0000_000A);
            chk($sformatf("stall%0d.WrEn", i), 32'(WrEn), 32'd1);
            chk($sformatf("stall%0d.RetCnt", i), RetCnt, cnt_before);
        end

        // Stall+Flush together with a valid incoming instruction gives a bubble
        Flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd3, 32'h55, 32'd0);
        cycle("stall_flush");
        chk("stall_flush.wb_valid", 32'(wb_valid), 32'd0);
        chk("stall_flush.WrEn", 32'(WrEn), 32'd0);
        chk("stall_flush.RetCnt", RetCnt, cnt_before);
        Stall = 1'b0; Flush = 1'b0;

        // Back-to-back writes to $3; rf reflects each one cycle after it shows on busW
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd3, 32'd1, 32'd0);
        cycle("b2b_1");
        chk("b2b_1.busW", busW, 32'd1);
        drive(1'b1, 1'b1, 1'b0, 3'd0, 5'd3, 32'd2, 32'd0);
        cycle("b2b_2");
        chk("b2b_2.rf3", rf[3], 32'd1);
        chk("b2b_2.busW", busW, 32'd2);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
        cycle("b2b_3");
        chk("b2b_3.rf3", rf[3], 32'd2);

        // Randomised traffic against the model, including occasional async resets
        for (int i = 0; i < 400; i++) begin
            Stall = ($urandom_range(0, 3) == 0);
            Flush = ($urandom_range(0, 7) == 0);
            drive(1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 5'($urandom),
                  $urandom, $urandom);
            if ($urandom_range(0, 49) == 0) async_reset_pulse($sformatf("rnd_rst%0d", i));
            cycle($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete, got time %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
MEM/WB pipeline register and write-back unit. It captures the memory-stage result and extracts and extends load data. It then drives the register-file write port (WrEn, Rw, busW). The register file samples this port on the falling edge of Clk, so values registered here on the rising edge are written in the same cycle.

Parameters:
DW, 32, datapath width; only 32 is supported.
AW, 5, register index width.

Ports:
Clk  in  1  system clock; all state updates on posedge.
Rst  in  1  asynchronous, active-high reset.
Stall  in  1  hold WB register contents.
Flush  in  1  invalidate the incoming instruction.
mem_valid  in  1  MEM stage holds a real instruction.
mem_RegWr  in  1  instruction writes a GPR.
mem_MemtoReg  in  1  1 = load data, 0 = ALU result.
mem_LdType  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others treated as lw.
mem_Rw  in  5  destination register.
mem_ALUout  in  32  ALU result / effective address.
mem_dout  in  32  aligned word read from data memory.
WrEn  out  1  register-file write enable.
Rw  out  5  register-file write index.
busW  out  32  register-file write data.
wb_valid  out  1  WB register holds a valid instruction.
RetCnt  out  32  retired-instruction counter (see Optional Feature).

Behaviour:
- Reset (async, Rst=1): wb_valid=0, Rw=0, busW=0, RetCnt=0, hence WrEn=0. Reset mid-stall or mid-flush wins over everything.
- Posedge update priority: Rst > Flush > Stall > load.
  - Flush=1: wb_valid<=0. Rw and busW keep their old values.
  - Stall=1 and Flush=0: all WB registers hold.
  - Otherwise: wb_valid<=mem_valid; the control fields, Rw<=mem_Rw and busW<=result are loaded.
- Latency: exactly 1 cycle from MEM inputs to busW/Rw. The register file writes on the following negedge.
- Result selection, computed combinationally from MEM inputs and then registered:
  - MemtoReg=0: result=mem_ALUout.
  - MemtoReg=1: use byte offset a=mem_ALUout[1:0]. Ordering is little-endian: byte 0 = mem_dout[7:0].
    - lw: mem_dout.
    - lb/lbu: byte a, sign- or zero-extended to 32 bits.
    - lh/lhu: halfword a[1] (a[1]=0 → [15:0], a[1]=1 → [31:16]), sign- or zero-extended. a[0] is ignored; misaligned halfwords are not trapped.
    - LdType 101–111: lw.
- WrEn = wb_valid & wb_RegWr & (Rw != 0). Writes to $0 are always suppressed.
- While stalled, WrEn stays asserted for a valid writing instruction. The repeated write of the same value is harmless and intended.
- If Stall and Flush are asserted together, the Flush result applies (bubble).
- No internal hazard detection. Forwarding consumers may observe Rw/busW/WrEn directly.

Optional Feature:
- Macro WB_RETCNT_EN.
- Defined: RetCnt increments by 1 on each posedge where a valid instruction is loaded into the WB register (Rst=0, Flush=0, Stall=0, mem_valid=1). It counts writing and non-writing instructions alike. The count wraps modulo 2^32.
- Undefined: RetCnt is tied to 0 and no counter flops are generated.

Test Plan:
1. Rst=1 asserted asynchronously between edges → WrEn=0, busW=0, Rw=0, wb_valid=0 immediately. After release, the first valid lw of mem_dout=0x12345678 to $8 → next cycle WrEn=1, Rw=8, busW=0x12345678.
2. Load extraction, mem_dout=0x80FF7F01:
   - lb, a=2 → 0xFFFFFFFF.
   - lbu, a=3 → 0x00000080.
   - lh, a=2 → 0xFFFF80FF.
   - lhu, a=1 → 0x00007F01.
   - LdType=111 → 0x80FF7F01.
3. ALU write to $0 (mem_RegWr=1, mem_Rw=0, ALUout=5) → WrEn=0. A subsequent read of $0 through the register file still returns 0.
4. Valid add to $9 (busW=0x0000000A), then Stall=1 for 3 cycles while the MEM inputs change → Rw=9, busW=0x0000000A and WrEn=1 held all 3 cycles. With WB_RETCNT_EN, RetCnt increments once only.
5. Stall=1 and Flush=1 together with a valid instruction at the input → next cycle wb_valid=0, WrEn=0. RetCnt is unchanged.
6. Back-to-back writes to $3 (value 1) then $3 (value 2), with register-file reads of $3 each cycle → the read value reflects each write one cycle after it appears on busW. With WB_RETCNT_EN, RetCnt preloaded via 2^32−1 valid loads wraps to 0.
